// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions (riscv_defs): opcodes, line geometry, immediate decoders and FSM encodings.
package inst_fetch_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned ROW_W      = 512;

  localparam logic [0:0] ST_FETCH    = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } dec_out_t;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache: tag/valid/data arrays, combinational hit and word read,
// one full-line fill port. Valid bits clear on rst.
module inst_fetch_icache import inst_fetch_pkg::*; #(
  parameter int unsigned LINE_IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rd_pc,
  output logic             rd_hit,
  output logic [31:0]      rd_word,
  input  logic             wr_en,
  input  logic [31:0]      wr_pc,
  input  logic [ROW_W-1:0] wr_row
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W = 32 - OFF_W - LINE_IDX_W;
  localparam int unsigned LINES = 1 << LINE_IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [ROW_W-1:0] data_q [LINES];

  logic [LINE_IDX_W-1:0] rd_idx_s;
  logic [LINE_IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0]      rd_tag_s;
  logic [TAG_W-1:0]      wr_tag_s;
  logic [OFF_W-3:0]      rd_off_s;
  logic                  unused_s;

  assign rd_idx_s = rd_pc[OFF_W +: LINE_IDX_W];
  assign rd_tag_s = rd_pc[31 -: TAG_W];
  assign rd_off_s = rd_pc[OFF_W-1:2];
  assign wr_idx_s = wr_pc[OFF_W +: LINE_IDX_W];
  assign wr_tag_s = wr_pc[31 -: TAG_W];
  assign unused_s = ^{rd_pc[1:0], wr_pc[OFF_W-1:0]};

  assign rd_hit  = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
  assign rd_word = data_q[rd_idx_s][{rd_off_s, 5'b00000} +: 32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx_s]  <= wr_tag_s;
      data_q[wr_idx_s] <= wr_row;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: I-cache lookup, line refill FSM, decoder output registers.
// Optional branch prediction is enabled by defining IFETCH_BHT_EN.
module inst_fetch import inst_fetch_pkg::*; #(
  parameter int unsigned LINE_IDX_W = 2,
  parameter int unsigned BHT_IDX_W  = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic [31:0]      rollback_pc,
  output logic             inst_config,
  output logic [31:0]      inst_PC,
  input  logic [ROW_W-1:0] inst_row,
  input  logic             inst_out_config,
  input  logic             dec_stall,
  output logic             dec_valid,
  output logic [31:0]      dec_inst,
  output logic [31:0]      dec_pc,
  output logic             dec_pred_jump,
  input  logic             bht_upd_valid,
  input  logic [31:0]      bht_upd_pc,
  input  logic             bht_upd_taken
);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] miss_pc_q, miss_pc_d;
  logic        req_q, req_d;
  logic [31:0] req_pc_q, req_pc_d;
  dec_out_t    dec_q, dec_d;

  logic        hit_s;
  logic [31:0] word_s;
  logic        fill_we_s;
  logic        pred_s;
  logic [31:0] next_pc_s;

  inst_fetch_icache #(.LINE_IDX_W(LINE_IDX_W)) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_pc   (pc_q),
    .rd_hit  (hit_s),
    .rd_word (word_s),
    .wr_en   (fill_we_s),
    .wr_pc   (miss_pc_q),
    .wr_row  (inst_row)
  );

`ifdef IFETCH_BHT_EN
  localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_ENTRIES];
  logic [BHT_IDX_W-1:0] bht_rd_idx_s;
  logic [BHT_IDX_W-1:0] bht_wr_idx_s;
  logic                 unused_bht_s;

  assign bht_rd_idx_s = pc_q[BHT_IDX_W+1:2];
  assign bht_wr_idx_s = bht_upd_pc[BHT_IDX_W+1:2];
  assign unused_bht_s = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

  // A lookup in the same cycle as an update of the same entry sees the old counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (rdy && bht_upd_valid) begin
      if (bht_upd_taken) begin
        if (bht_q[bht_wr_idx_s] != 2'b11) bht_q[bht_wr_idx_s] <= bht_q[bht_wr_idx_s] + 2'd1;
      end else begin
        if (bht_q[bht_wr_idx_s] != 2'b00) bht_q[bht_wr_idx_s] <= bht_q[bht_wr_idx_s] - 2'd1;
      end
    end
  end

  always_comb begin
    pred_s    = 1'b0;
    next_pc_s = pc_q + 32'd4;
    if (word_s[6:0] == OPC_JAL) begin
      pred_s    = 1'b1;
      next_pc_s = pc_q + j_imm(word_s);
    end else if ((word_s[6:0] == OPC_BRANCH) && bht_q[bht_rd_idx_s][1]) begin
      pred_s    = 1'b1;
      next_pc_s = pc_q + b_imm(word_s);
    end else begin
      pred_s    = 1'b0;
      next_pc_s = pc_q + 32'd4;
    end
  end
`else
  logic                 unused_upd_s;
  logic [BHT_IDX_W-1:0] unused_bht_idx_s;

  assign unused_upd_s     = ^{bht_upd_valid, bht_upd_pc, bht_upd_taken};
  assign unused_bht_idx_s = bht_upd_pc[BHT_IDX_W+1:2];
  assign pred_s           = 1'b0;
  assign next_pc_s        = pc_q + 32'd4;
`endif

  // Rollback outranks everything but still lets a coinciding refill land under miss_pc.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    miss_pc_d = miss_pc_q;
    req_d     = req_q;
    req_pc_d  = req_pc_q;
    dec_d     = dec_q;
    dec_d.valid = 1'b0;
    fill_we_s = 1'b0;
    if (!rdy) begin
      fill_we_s = 1'b0;
    end else if (rollback) begin
      pc_d      = rollback_pc;
      req_d     = 1'b0;
      state_d   = ST_FETCH;
      fill_we_s = (state_q == ST_WAIT_MEM) && inst_out_config;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (hit_s) begin
            if (!dec_stall) begin
              dec_d.valid = 1'b1;
              dec_d.inst  = word_s;
              dec_d.pc    = pc_q;
              dec_d.pred  = pred_s;
              pc_d        = next_pc_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            miss_pc_d = pc_q;
            req_d     = 1'b1;
            req_pc_d  = pc_q;
            state_d   = ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          if (inst_out_config) begin
            fill_we_s = 1'b1;
            req_d     = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            req_d = 1'b1;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      miss_pc_q <= 32'h0000_0000;
      req_q     <= 1'b0;
      req_pc_q  <= 32'h0000_0000;
      dec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      miss_pc_q <= miss_pc_d;
      req_q     <= req_d;
      req_pc_q  <= req_pc_d;
      dec_q     <= dec_d;
    end
  end

  assign inst_config   = req_q;
  assign inst_PC       = req_pc_q;
  assign dec_valid     = dec_q.valid;
  assign dec_inst      = dec_q.inst;
  assign dec_pc        = dec_q.pc;
  assign dec_pred_jump = dec_q.pred;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed fetch streams, a line-serving memory model and an issue monitor.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback, dec_stall;
  logic [31:0]  rollback_pc;
  logic         inst_config, inst_out_config;
  logic [31:0]  inst_PC;
  logic [511:0] inst_row;
  logic         dec_valid, dec_pred_jump;
  logic [31:0]  dec_inst, dec_pc;
  logic         bht_upd_valid, bht_upd_taken;
  logic [31:0]  bht_upd_pc;

  always #5 clk = ~clk;

  inst_fetch #(.LINE_IDX_W(2), .BHT_IDX_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .inst_config(inst_config), .inst_PC(inst_PC), .inst_row(inst_row),
    .inst_out_config(inst_out_config), .dec_stall(dec_stall), .dec_valid(dec_valid),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_pred_jump(dec_pred_jump),
    .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic pred; } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          pop_cyc[$];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, granted = 0, served = 0, mem_cnt = 0;
  logic        stall_e = 1'b0, rdy_e = 1'b1, cfg_prev = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0210) return 32'h0080_006F;      // jal x0, +8
    else if (a == 32'h0000_0220) return 32'h0000_0863; // beq x0, x0, +16
    else return {2'b00, a[31:2]};
  endfunction

  function automatic logic [511:0] make_row(input logic [31:0] a);
    logic [511:0] r;
    logic [31:0]  base;
    base = {a[31:6], 6'b000000};
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = mem_word(base + 32'(i * 4));
    return r;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    stall_e <= dec_stall;
    rdy_e   <= rdy;
  end

  // Memory: logs each new request, answers after three cycles while grants remain.
  always @(negedge clk) begin
    inst_out_config = 1'b0;
    if (rst) begin
      mem_cnt  = 0;
      cfg_prev = 1'b0;
    end else begin
      if (inst_config && !cfg_prev) req_log.push_back(inst_PC);
      cfg_prev = inst_config;
      if (inst_config && served < granted) begin
        mem_cnt++;
        if (mem_cnt == 3) begin
          inst_out_config = 1'b1;
          inst_row        = make_row(inst_PC);
          served++;
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Issue monitor: pops the scoreboard on every dec_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dec_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL issue: unexpected dec_pc=%h dec_inst=%h", dec_pc, dec_inst);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if (dec_pc !== e.pc || dec_inst !== e.inst || dec_pred_jump !== e.pred || stall_e || !rdy_e) begin
          miscompares++;
          $display("FAIL issue: got pc=%h inst=%h pred=%b (stall=%b rdy=%b) expected pc=%h inst=%h pred=%b",
                   dec_pc, dec_inst, dec_pred_jump, stall_e, rdy_e, e.pc, e.inst, e.pred);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    else return 32'hDEAD_BEEF;
  endfunction

  task automatic push_exp(input logic [31:0] pc, input logic pred);
    exp_t e;
    e.pc = pc; e.inst = mem_word(pc); e.pred = pred;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] p = lo; p <= hi; p += 32'd4) push_exp(p, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d issues outstanding after timeout", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_rollback(input logic [31:0] pc);
    rollback = 1'b1; rollback_pc = pc;
    @(negedge clk);
    rollback = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = 32'h0; dec_stall = 1'b0;
    inst_out_config = 1'b0; inst_row = '0;
    bht_upd_valid = 1'b0; bht_upd_pc = 32'h0; bht_upd_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inst_config", {31'b0, inst_config}, 32'h0);
    chk("rst_inst_PC", inst_PC, 32'h0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_pred", {31'b0, dec_pred_jump}, 32'h0);

    // Cold start: one fill of line 0, then sixteen issues, then a miss on 0x40 left unanswered.
    push_seq(32'h00, 32'h3C);
    granted = 1;
    rst = 1'b0;
    wait_drain("t1_cold_stream");
    chk("t1_req_count", 32'(req_log.size()), 32'd2);
    chk("t1_req0", req_at(0), 32'h0000_0000);
    chk("t1_req1", req_at(1), 32'h0000_0040);
    chk("t1_cfg_held", {31'b0, inst_config}, 32'h1);
    chk("t1_pc_held", inst_PC, 32'h0000_0040);

    // Rollback out of WAIT_MEM; 0x100 conflicts with line 0 in index 0.
    n0 = req_log.size();
    push_seq(32'h100, 32'h13C);
    granted++;
    do_rollback(32'h100);
    chk("t4_cfg_drop", {31'b0, inst_config}, 32'h0);
    wait_drain("t4_stream");
    chk("t4_req_count", 32'(req_log.size() - n0), 32'd2);
    chk("t4_req_100", req_at(n0), 32'h0000_0100);
    chk("t4_req_140", req_at(n0 + 1), 32'h0000_0140);

    // Line 0 was evicted: refetch misses again; a short rdy pause mid-stream.
    n0 = req_log.size();
    push_seq(32'h00, 32'h3C);
    granted++;
    do_rollback(32'h000);
    for (int i = 0; i < 100 && exp_q.size() > 10; i++) @(negedge clk);
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    wait_drain("t5_refetch_stream");
    chk("t5_req_count", 32'(req_log.size() - n0), 32'd2);
    chk("t5_req_000", req_at(n0), 32'h0000_0000);

    // Second pass over the cached line: no line-0 request, one issue per cycle.
    n0 = req_log.size();
    pop_cyc.delete();
    push_seq(32'h00, 32'h3C);
    do_rollback(32'h000);
    wait_drain("t2_hit_stream");
    chk("t2_pops", 32'(pop_cyc.size()), 32'd16);
    if (pop_cyc.size() == 16) chk("t2_back_to_back", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);
    chk("t2_req_count", 32'(req_log.size() - n0), 32'd1);
    chk("t2_req_040", req_at(n0), 32'h0000_0040);

    // Three stall cycles while pc=0x08 is up for issue.
    pop_cyc.delete();
    push_seq(32'h00, 32'h3C);
    do_rollback(32'h000);
    @(negedge clk);
    @(negedge clk);
    dec_stall = 1'b1;
    repeat (3) @(negedge clk);
    dec_stall = 1'b0;
    wait_drain("t3_stall_stream");
    if (pop_cyc.size() >= 3) chk("t3_stall_gap", 32'(pop_cyc[2] - pop_cyc[1]), 32'd4);
    else chk("t3_pops", 32'(pop_cyc.size()), 32'd16);

    // Line 0x200 holds a JAL +8 at 0x210 and a BEQ +16 at 0x220.
    n0 = req_log.size();
`ifdef IFETCH_BHT_EN
    push_seq(32'h200, 32'h20C);
    push_exp(32'h210, 1'b1);
    push_seq(32'h218, 32'h23C);
`else
    push_seq(32'h200, 32'h23C);
`endif
    granted++;
    do_rollback(32'h200);
    wait_drain("t6_untrained_stream");
    chk("t6_req_200", req_at(n0), 32'h0000_0200);
    chk("t6_req_240", req_at(n0 + 1), 32'h0000_0240);

    bht_upd_valid = 1'b1; bht_upd_pc = 32'h0000_0220; bht_upd_taken = 1'b1;
    repeat (2) @(negedge clk);
    bht_upd_valid = 1'b0;
`ifdef IFETCH_BHT_EN
    push_exp(32'h220, 1'b1);
    push_seq(32'h230, 32'h23C);
`else
    push_seq(32'h220, 32'h23C);
`endif
    do_rollback(32'h220);
    wait_drain("t6_trained_stream");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
